// File: rtl/uart_core.sv
// uart_core: full-duplex UART with fractional 16x baud generator, FWFT TX/RX
// FIFOs, serializer/deserializer, sticky error bits and saturating overrun counts.

// First-word-fall-through FIFO with a registered head word.
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   fill
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DATA_WIDTH-1:0] head_reg;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign fill  = count_reg;
    assign head  = head_reg;
    // A write while full is rejected even if a pop happens in the same cycle.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    // Storage array, left without reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy; clr empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_wr && !do_rd) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Head word: bypass write data into an empty (or emptying) FIFO, else prefetch the next entry on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
        end else if (!clr) begin
            if (do_wr && (empty || (count_reg == ONE_COUNT && do_rd))) begin
                head_reg <= wr_data;
            end else if (do_rd && count_reg > ONE_COUNT) begin
                head_reg <= mem[rd_ptr_reg + 1'b1];
            end
        end
    end
endmodule

module uart_core #(
    parameter int DATA_WIDTH            = 8,
    parameter int TX_PARITY_EN          = 0,
    parameter int RX_PARITY_EN          = 0,
    parameter int BAUDGEN_COUNTER_WIDTH = 20,
    parameter int FIFO_ADDR_WIDTH       = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rstn,
    input  logic [BAUDGEN_COUNTER_WIDTH-1:0] i_divisor_x16,
    input  logic [3:0]                       i_fra_adj_x16,
    input  logic                             i_tx_wr,
    input  logic [DATA_WIDTH-1:0]            i_tx_data,
    output logic                             o_tx_full,
    output logic [FIFO_ADDR_WIDTH:0]         o_tx_fill,
    input  logic                             i_tx_fifo_rst,
    input  logic                             i_rx_rd,
    output logic [DATA_WIDTH-1:0]            o_rx_data,
    output logic                             o_rx_empty,
    output logic [FIFO_ADDR_WIDTH:0]         o_rx_fill,
    input  logic                             i_rx_fifo_rst,
    input  logic                             i_error_rst,
    output logic [1:0]                       o_uart_rx_error,
    output logic [3:0]                       o_fifo_tx_overrun,
    output logic [3:0]                       o_fifo_rx_overrun,
    input  logic                             i_RX,
    output logic                             o_TX
);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 3);
    localparam int TX_BITS = DATA_WIDTH + TX_PARITY_EN + 2;
    localparam logic [BIT_W-1:0] TX_LAST = BIT_W'(TX_BITS - 1);
    localparam logic [BIT_W-1:0] RX_LAST = BIT_W'(DATA_WIDTH + RX_PARITY_EN);
    localparam logic [BIT_W-1:0] RX_DW   = BIT_W'(DATA_WIDTH);
    localparam logic [BAUDGEN_COUNTER_WIDTH:0] BAUD_ONE = {{BAUDGEN_COUNTER_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

    // ---------------- baud generator ----------------
    logic [BAUDGEN_COUNTER_WIDTH:0] baud_cnt_reg;
    logic [BAUDGEN_COUNTER_WIDTH:0] baud_limit;
    logic [3:0]                     phase_reg;
    logic                           tick_reg;

    // The first fra_adj phases of every 16 get one extra clock.
    assign baud_limit = {1'b0, i_divisor_x16}
                      + {{BAUDGEN_COUNTER_WIDTH{1'b0}}, (phase_reg < i_fra_adj_x16)};

    // Tick counter: one-clock tick at the end of each phase period; divisor 0 stalls.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            baud_cnt_reg <= '0;
            phase_reg    <= '0;
            tick_reg     <= 1'b0;
        end else if (i_divisor_x16 == '0) begin
            baud_cnt_reg <= '0;
            tick_reg     <= 1'b0;
        end else if (baud_cnt_reg + BAUD_ONE >= baud_limit) begin
            baud_cnt_reg <= '0;
            phase_reg    <= phase_reg + 4'd1;
            tick_reg     <= 1'b1;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
            tick_reg     <= 1'b0;
        end
    end

    // ---------------- FIFOs ----------------
    logic                  tx_empty;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  rx_push;
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] rx_data_reg;

    uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) tx_fifo (
        .clk(i_clk), .rst_n(i_rstn), .clr(i_tx_fifo_rst),
        .wr(i_tx_wr), .wr_data(i_tx_data), .rd(tx_pop),
        .head(tx_head), .full(o_tx_full), .empty(tx_empty), .fill(o_tx_fill)
    );

    uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) rx_fifo (
        .clk(i_clk), .rst_n(i_rstn), .clr(i_rx_fifo_rst),
        .wr(rx_push), .wr_data(rx_data_reg), .rd(i_rx_rd),
        .head(o_rx_data), .full(rx_full), .empty(o_rx_empty), .fill(o_rx_fill)
    );

    // ---------------- transmitter ----------------
    tx_state_t          tx_state_reg, tx_state_next;
    logic [TX_BITS-1:0] tx_shift_reg;
    logic [TX_BITS-1:0] tx_frame;
    logic [3:0]         tx_tick_reg;
    logic [BIT_W-1:0]   tx_bit_reg;

    generate
        if (TX_PARITY_EN != 0) begin : g_tx_par
            assign tx_frame = {1'b1, ^tx_head, tx_head, 1'b0};
        end else begin : g_tx_nopar
            assign tx_frame = {1'b1, tx_head, 1'b0};
        end
    endgenerate

    assign o_TX = (tx_state_reg == TX_SEND) ? tx_shift_reg[0] : 1'b1;

    // TX state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) tx_state_reg <= TX_IDLE;
        else         tx_state_reg <= tx_state_next;
    end

    // TX next state: pop when idle, align start bit to a tick, 16 ticks per bit.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE: if (!tx_empty) begin
                tx_pop        = 1'b1;
                tx_state_next = TX_WAIT;
            end
            TX_WAIT: if (tick_reg) tx_state_next = TX_SEND;
            TX_SEND: if (tick_reg && tx_tick_reg == 4'd15 && tx_bit_reg == TX_LAST) begin
                tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX shifter: load the framed character on pop, shift after every 16th tick.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tx_shift_reg <= '1;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
        end else if (tx_pop) begin
            tx_shift_reg <= tx_frame;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
        end else if (tx_state_reg == TX_SEND && tick_reg) begin
            tx_tick_reg <= tx_tick_reg + 4'd1;
            if (tx_tick_reg == 4'd15) begin
                tx_shift_reg <= {1'b1, tx_shift_reg[TX_BITS-1:1]};
                tx_bit_reg   <= tx_bit_reg + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    rx_state_t        rx_state_reg, rx_state_next;
    logic             rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    logic [3:0]       rx_tick_reg;
    logic [BIT_W-1:0] rx_bit_reg;
    logic             rx_par_reg;
    logic             rx_sample;
    logic             rx_stop;
    logic             rx_framing_err;
    logic             rx_parity_err;

    assign rx_framing_err = rx_stop && !rx_sync2_reg;
    assign rx_parity_err  = rx_stop && rx_sync2_reg && (RX_PARITY_EN != 0) && rx_par_reg;
    assign rx_push        = rx_stop && rx_sync2_reg && !rx_parity_err;

    // Two-flop synchronizer plus previous value for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_sync1_reg <= i_RX;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
        end
    end

    // RX state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rx_state_reg <= RX_IDLE;
        else         rx_state_reg <= rx_state_next;
    end

    // RX next state: confirm start at mid-bit, then sample every 16 ticks up to the stop bit.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_sample     = 1'b0;
        rx_stop       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: if (rx_prev_reg && !rx_sync2_reg) rx_state_next = RX_START;
            RX_START: if (tick_reg && rx_tick_reg == 4'd7) begin
                rx_state_next = rx_sync2_reg ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick_reg && rx_tick_reg == 4'd15) begin
                rx_sample = 1'b1;
                if (rx_bit_reg == RX_LAST) begin
                    rx_stop       = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // RX datapath: tick/bit counters, LSB-first data shift and running parity.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_tick_reg <= '0;
            rx_bit_reg  <= '0;
            rx_data_reg <= '0;
            rx_par_reg  <= 1'b0;
        end else begin
            if (rx_state_reg == RX_IDLE) begin
                rx_tick_reg <= '0;
            end else if (tick_reg) begin
                rx_tick_reg <= rx_tick_reg + 4'd1;
            end
            if (rx_state_reg == RX_START && tick_reg && rx_tick_reg == 4'd7) begin
                rx_tick_reg <= '0;
                rx_bit_reg  <= '0;
                rx_par_reg  <= 1'b0;
            end
            if (rx_sample && !rx_stop) begin
                rx_bit_reg <= rx_bit_reg + 1'b1;
                rx_par_reg <= rx_par_reg ^ rx_sync2_reg;
                if (rx_bit_reg < RX_DW) begin
                    rx_data_reg <= {rx_sync2_reg, rx_data_reg[DATA_WIDTH-1:1]};
                end
            end
        end
    end

    // ---------------- status ----------------
    logic [1:0] err_reg;
    logic [3:0] tx_ovr_reg;
    logic [3:0] rx_ovr_reg;

    assign o_uart_rx_error   = err_reg;
    assign o_fifo_tx_overrun = tx_ovr_reg;
    assign o_fifo_rx_overrun = rx_ovr_reg;

    // Sticky error bits and saturating overrun counters; only i_error_rst clears them.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_reg    <= '0;
            tx_ovr_reg <= '0;
            rx_ovr_reg <= '0;
        end else if (i_error_rst) begin
            err_reg    <= '0;
            tx_ovr_reg <= '0;
            rx_ovr_reg <= '0;
        end else begin
            if (rx_framing_err) err_reg[0] <= 1'b1;
            if (rx_parity_err)  err_reg[1] <= 1'b1;
            if (i_tx_wr && o_tx_full && tx_ovr_reg != 4'hF) tx_ovr_reg <= tx_ovr_reg + 4'd1;
            if (rx_push && rx_full && rx_ovr_reg != 4'hF)   rx_ovr_reg <= rx_ovr_reg + 4'd1;
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven bit-timing vectors in loopback, randomized
// loopback and RX-overrun runs against a queue model, plus corner sequences.
module tb_uart_core;
    logic        clk = 1'b0;
    logic        rstn;
    logic [19:0] divisor;
    logic [3:0]  fra;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic [4:0]  tx_fill;
    logic        tx_fifo_rst;
    logic        rx_rd;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic [4:0]  rx_fill;
    logic        rx_fifo_rst;
    logic        error_rst;
    logic [1:0]  rx_error;
    logic [3:0]  tx_ovr;
    logic [3:0]  rx_ovr;
    logic        tx_line;
    logic        loopback;
    logic        rx_drv;
    logic        serial_in;

    int checks = 0;
    int errors = 0;

    assign serial_in = loopback ? tx_line : rx_drv;

    always #20 clk = ~clk;

    uart_core dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_divisor_x16(divisor), .i_fra_adj_x16(fra),
        .i_tx_wr(tx_wr), .i_tx_data(tx_data),
        .o_tx_full(tx_full), .o_tx_fill(tx_fill), .i_tx_fifo_rst(tx_fifo_rst),
        .i_rx_rd(rx_rd), .o_rx_data(rx_data), .o_rx_empty(rx_empty),
        .o_rx_fill(rx_fill), .i_rx_fifo_rst(rx_fifo_rst),
        .i_error_rst(error_rst), .o_uart_rx_error(rx_error),
        .o_fifo_tx_overrun(tx_ovr), .o_fifo_rx_overrun(rx_ovr),
        .i_RX(serial_in), .o_TX(tx_line)
    );

    typedef struct {
        logic [19:0] div;
        logic [3:0]  fra;
        logic [7:0]  data;
        int          low_clks;  // clocks o_TX stays low from the start bit
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] model_q[$];
    int         model_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("check %s ok value=%0h", name, act);
        end
    endtask

    task automatic pulse(input int which);
        @(posedge clk); #1;
        if (which == 0) tx_fifo_rst = 1'b1;
        else if (which == 1) rx_fifo_rst = 1'b1;
        else error_rst = 1'b1;
        @(posedge clk); #1;
        tx_fifo_rst = 1'b0;
        rx_fifo_rst = 1'b0;
        error_rst   = 1'b0;
    endtask

    task automatic read_rx(input logic [7:0] exp, input string name);
        @(negedge clk);
        check(name, 32'(rx_data), 32'(exp));
        rx_rd = 1'b1;
        @(posedge clk); #1;
        rx_rd = 1'b0;
    endtask

    task automatic send_bit(input logic v);
        @(posedge clk); #1;
        rx_drv = v;
        repeat (15) @(posedge clk);
    endtask

    // One frame on the RX pin at 16 clocks per bit (divisor 1 gives one tick per clock).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"},       32'(tx_line), 32'd1);
        check({tag, "_tx_fill"},  32'(tx_fill), 32'd0);
        check({tag, "_tx_full"},  32'(tx_full), 32'd0);
        check({tag, "_rx_empty"}, 32'(rx_empty), 32'd1);
        check({tag, "_rx_fill"},  32'(rx_fill), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data), 32'd0);
        check({tag, "_rx_error"}, 32'(rx_error), 32'd0);
        check({tag, "_tx_ovr"},   32'(tx_ovr), 32'd0);
        check({tag, "_rx_ovr"},   32'(rx_ovr), 32'd0);
    endtask

    initial begin
        #3_600_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        int low;
        logic [7:0] b;

        // Start-bit low time = (leading zero bits incl. start) * 16 ticks of the fractional period.
        vecs[0] = '{div: 20'd13, fra: 4'd6,  data: 8'h01, low_clks: 214};
        vecs[1] = '{div: 20'd13, fra: 4'd6,  data: 8'h00, low_clks: 9 * 214};
        vecs[2] = '{div: 20'd13, fra: 4'd0,  data: 8'h01, low_clks: 208};
        vecs[3] = '{div: 20'd13, fra: 4'd15, data: 8'h01, low_clks: 223};
        vecs[4] = '{div: 20'd4,  fra: 4'd8,  data: 8'h02, low_clks: 144};
        vecs[5] = '{div: 20'd2,  fra: 4'd3,  data: 8'h80, low_clks: 280};

        rstn = 1'b0; divisor = 20'd13; fra = 4'd6;
        tx_wr = 1'b0; tx_data = 8'h00; tx_fifo_rst = 1'b0;
        rx_rd = 1'b0; rx_fifo_rst = 1'b0; error_rst = 1'b0;
        loopback = 1'b1; rx_drv = 1'b1;
        #100;
        check_reset_values("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Table vectors in loopback: pop latency, bit timing, and received byte.
        for (int i = 0; i < 6; i++) begin
            divisor = vecs[i].div;
            fra     = vecs[i].fra;
            repeat (40) @(posedge clk);
            @(posedge clk); #1;
            tx_wr = 1'b1; tx_data = vecs[i].data;
            @(posedge clk); #1;
            tx_wr = 1'b0;
            @(negedge clk);
            check("vec_tx_fill_after_write", 32'(tx_fill), 32'd1);
            @(negedge clk);
            check("vec_tx_fill_after_pop", 32'(tx_fill), 32'd0);
            n = 0;
            while (tx_line !== 1'b0 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("vec_start_bit_seen", 32'(tx_line), 32'd0);
            low = 0;
            while (tx_line === 1'b0 && low < 20000) begin
                low++;
                @(negedge clk);
            end
            check("vec_low_clocks", 32'(low), 32'(vecs[i].low_clks));
            n = 0;
            while (rx_empty && n < 40000) begin
                @(negedge clk);
                n++;
            end
            check("vec_rx_arrived", 32'(rx_empty), 32'd0);
            read_rx(vecs[i].data, "vec_rx_data");
            check("vec_rx_error", 32'(rx_error), 32'd0);
            repeat (600) @(posedge clk);
        end

        // Random loopback: 16 bytes, all must arrive in order.
        divisor = 20'd3; fra = 4'd5;
        repeat (100) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            b = 8'($urandom_range(0, 255));
            tx_wr = 1'b1; tx_data = b;
            model_q.push_back(b);
        end
        @(posedge clk); #1;
        tx_wr = 1'b0;
        n = 0;
        while (rx_fill != 5'd16 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("lb16_rx_fill", 32'(rx_fill), 32'd16);
        while (model_q.size() > 0) read_rx(model_q.pop_front(), "lb16_rx_data");
        @(negedge clk);
        check("lb16_rx_empty", 32'(rx_empty), 32'd1);
        check("lb16_rx_error", 32'(rx_error), 32'd0);
        check("lb16_tx_ovr", 32'(tx_ovr), 32'd0);
        check("lb16_rx_ovr", 32'(rx_ovr), 32'd0);

        // Eight bytes at divisor 13 + 6/16, fixed wait, then read back.
        divisor = 20'd13; fra = 4'd6;
        repeat (100) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            b = 8'($urandom_range(0, 255));
            tx_wr = 1'b1; tx_data = b;
            model_q.push_back(b);
        end
        @(posedge clk); #1;
        tx_wr = 1'b0;
        repeat (20000) @(posedge clk);
        @(negedge clk);
        check("lb8_rx_fill", 32'(rx_fill), 32'd8);
        while (model_q.size() > 0) read_rx(model_q.pop_front(), "lb8_rx_data");
        @(negedge clk);
        check("lb8_rx_empty", 32'(rx_empty), 32'd1);

        // TX overrun: 20 back-to-back writes into an idle transmitter.
        loopback = 1'b0; rx_drv = 1'b1;
        repeat (600) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            tx_wr = 1'b1; tx_data = 8'(i);
        end
        @(posedge clk); #1;
        tx_wr = 1'b0;
        @(negedge clk);
        check("txovr_full", 32'(tx_full), 32'd1);
        check("txovr_fill", 32'(tx_fill), 32'd16);
        check("txovr_count", 32'(tx_ovr), 32'd3);
        pulse(0);
        @(negedge clk);
        check("txovr_fill_after_fifo_rst", 32'(tx_fill), 32'd0);
        check("txovr_count_after_fifo_rst", 32'(tx_ovr), 32'd3);
        pulse(2);
        @(negedge clk);
        check("txovr_count_after_error_rst", 32'(tx_ovr), 32'd0);
        // Character already in the shifter keeps going; reset it mid-frame.
        n = 0;
        while (tx_line !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("midframe_tx_low", 32'(tx_line), 32'd0);
        repeat (100) @(negedge clk);
        #5 rstn = 1'b0;
        #1;
        check_reset_values("midframe_reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // RX overrun: 21 frames into a 16-deep FIFO, compared against a queue model.
        divisor = 20'd1; fra = 4'd0;
        model_ovr = 0;
        repeat (50) @(posedge clk);
        for (int i = 0; i < 21; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            if (model_q.size() < 16) model_q.push_back(b);
            else if (model_ovr < 15) model_ovr++;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("rxovr_fill", 32'(rx_fill), 32'(model_q.size()));
        check("rxovr_count", 32'(rx_ovr), 32'(model_ovr));
        check("rxovr_error", 32'(rx_error), 32'd0);
        while (model_q.size() > 0) read_rx(model_q.pop_front(), "rxovr_data");
        pulse(2);
        @(negedge clk);
        check("rxovr_count_cleared", 32'(rx_ovr), 32'd0);

        // Framing error: stop bit sampled low, byte discarded; error is sticky.
        send_frame(8'hA5, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("framing_error", 32'(rx_error), 32'd1);
        check("framing_no_push", 32'(rx_fill), 32'd0);
        send_frame(8'h3C, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("after_framing_fill", 32'(rx_fill), 32'd1);
        read_rx(8'h3C, "after_framing_data");
        check("framing_sticky", 32'(rx_error), 32'd1);
        pulse(2);
        @(negedge clk);
        check("framing_cleared", 32'(rx_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
